// File: rtl/ariane_pkg.sv
// ============================================================================
// ariane_pkg : functional-unit class and FLU writeback-owner encodings.
// Rev 1.0
// ============================================================================
`default_nettype none

package ariane_pkg;

    typedef enum logic [2:0] {
        FU_NONE    = 3'd0,
        ALU        = 3'd1,
        CTRL_FLOW  = 3'd2,
        CSR        = 3'd3,
        MULT       = 3'd4,
        DIV        = 3'd5,
        LOAD_STORE = 3'd6,
        FPU        = 3'd7
    } fu_class_t;

    typedef enum logic [1:0] {
        WB_NONE   = 2'd0,
        WB_SINGLE = 2'd1,
        WB_MULT   = 2'd2,
        WB_DIV    = 2'd3
    } wb_sel_t;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    // Classes that write the FLU port in the same cycle they issue.
    function automatic logic is_single_cycle(input fu_class_t fu);
        return (fu == ALU) || (fu == CTRL_FLOW) || (fu == CSR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fu_issue_scheduler.sv
// ============================================================================
// fu_issue_scheduler : issue gating and FLU writeback-port arbitration.
// Rev 1.0
// ============================================================================
`default_nettype none

module fu_issue_scheduler
    import ariane_pkg::*;
#(
    parameter int unsigned MultLatency = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        issue_valid_i,
    input  fu_class_t   issue_fu_i,
    output logic        issue_ready_o,
    input  logic        lsu_ready_i,
    input  logic        fpu_ready_i,
    input  logic        div_done_i,
    input  logic        csr_commit_i,
    output logic        alu_valid_o,
    output logic        branch_valid_o,
    output logic        csr_valid_o,
    output logic        mult_valid_o,
    output logic        div_valid_o,
    output logic        lsu_valid_o,
    output logic        fpu_valid_o,
    output wb_sel_t     wb_sel_o,
    output logic [15:0] stall_cnt_o
);

    logic [MultLatency-1:0] rsv_q, rsv_d;
    logic                   div_busy_q, div_busy_d;
    logic                   csr_pending_q, csr_pending_d;
    logic [15:0]            stall_cnt_q, stall_cnt_d;

    logic class_ready;
    logic blocked;
    logic accept;

    always_comb begin
        class_ready = 1'b0;
        case (issue_fu_i)
            ALU, CTRL_FLOW, CSR: class_ready = !rsv_q[0] && !div_done_i;
            MULT:                class_ready = 1'b1;
            // Pending multiplies must drain before the divider may claim the port.
            DIV:                 class_ready = (rsv_q == '0);
            LOAD_STORE:          class_ready = lsu_ready_i;
            FPU:                 class_ready = fpu_ready_i;
            default:             class_ready = 1'b0;
        endcase
    end

    assign blocked       = flush_i || div_busy_q || csr_pending_q || (issue_fu_i == FU_NONE);
    assign issue_ready_o = !blocked && class_ready;
    assign accept        = issue_valid_i && issue_ready_o;

    assign alu_valid_o    = accept && (issue_fu_i == ALU);
    assign branch_valid_o = accept && (issue_fu_i == CTRL_FLOW);
    assign csr_valid_o    = accept && (issue_fu_i == CSR);
    assign mult_valid_o   = accept && (issue_fu_i == MULT);
    assign div_valid_o    = accept && (issue_fu_i == DIV);
    assign lsu_valid_o    = accept && (issue_fu_i == LOAD_STORE);
    assign fpu_valid_o    = accept && (issue_fu_i == FPU);

    always_comb begin
        wb_sel_o = WB_NONE;
        if (accept && is_single_cycle(issue_fu_i)) begin
            wb_sel_o = WB_SINGLE;
        end else if (rsv_q[0]) begin
            wb_sel_o = WB_MULT;
        end else if (div_done_i && div_busy_q) begin
            wb_sel_o = WB_DIV;
        end
    end

    always_comb begin
        rsv_d                = rsv_q >> 1;
        rsv_d[MultLatency-1] = rsv_d[MultLatency-1] | mult_valid_o;

        div_busy_d = div_busy_q;
        if (div_valid_o) begin
            div_busy_d = 1'b1;
        end else if (div_done_i) begin
            div_busy_d = 1'b0;
        end

        csr_pending_d = csr_pending_q;
        if (csr_valid_o) begin
            csr_pending_d = 1'b1;
        end else if (csr_commit_i) begin
            csr_pending_d = 1'b0;
        end

        if (flush_i) begin
            rsv_d         = '0;
            div_busy_d    = 1'b0;
            csr_pending_d = 1'b0;
        end

        // The stall counter deliberately ignores flush.
        stall_cnt_d = stall_cnt_q;
        if (issue_valid_i && !issue_ready_o && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsv_q         <= '0;
            div_busy_q    <= 1'b0;
            csr_pending_q <= 1'b0;
            stall_cnt_q   <= 16'd0;
        end else begin
            rsv_q         <= rsv_d;
            div_busy_q    <= div_busy_d;
            csr_pending_q <= csr_pending_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fu_issue_scheduler.sv
// ============================================================================
// tb_fu_issue_scheduler : directed vectors, corner sequences and a random
// phase checked against a small reference model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_fu_issue_scheduler;
    import ariane_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: MultLatency = 1
    logic        a_flush, a_valid, a_lsu, a_fpu, a_done, a_commit;
    fu_class_t   a_fu;
    logic        a_ready, a_alu, a_br, a_csr, a_mul, a_div, a_ls, a_fp;
    wb_sel_t     a_wb;
    logic [15:0] a_cnt;
    logic [6:0]  a_str;
    assign a_str = {a_alu, a_br, a_csr, a_mul, a_div, a_ls, a_fp};

    // Instance B: MultLatency = 3
    logic        b_flush, b_valid, b_lsu, b_fpu, b_done, b_commit;
    fu_class_t   b_fu;
    logic        b_ready, b_alu, b_br, b_csr, b_mul, b_div, b_ls, b_fp;
    wb_sel_t     b_wb;
    logic [15:0] b_cnt;

    fu_issue_scheduler #(.MultLatency(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
        .issue_valid_i(a_valid), .issue_fu_i(a_fu), .issue_ready_o(a_ready),
        .lsu_ready_i(a_lsu), .fpu_ready_i(a_fpu), .div_done_i(a_done),
        .csr_commit_i(a_commit),
        .alu_valid_o(a_alu), .branch_valid_o(a_br), .csr_valid_o(a_csr),
        .mult_valid_o(a_mul), .div_valid_o(a_div), .lsu_valid_o(a_ls),
        .fpu_valid_o(a_fp), .wb_sel_o(a_wb), .stall_cnt_o(a_cnt)
    );

    fu_issue_scheduler #(.MultLatency(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
        .issue_valid_i(b_valid), .issue_fu_i(b_fu), .issue_ready_o(b_ready),
        .lsu_ready_i(b_lsu), .fpu_ready_i(b_fpu), .div_done_i(b_done),
        .csr_commit_i(b_commit),
        .alu_valid_o(b_alu), .branch_valid_o(b_br), .csr_valid_o(b_csr),
        .mult_valid_o(b_mul), .div_valid_o(b_div), .lsu_valid_o(b_ls),
        .fpu_valid_o(b_fp), .wb_sel_o(b_wb), .stall_cnt_o(b_cnt)
    );

    typedef struct {
        logic      valid;
        fu_class_t fu;
        logic      lsu;
        logic      fpu;
        logic      done;
        logic      flush;
        logic      exp_ready;
        logic [6:0] exp_str;
        wb_sel_t   exp_wb;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_a(input logic v, input fu_class_t fu, input logic lsu, input logic fpu,
                         input logic done, input logic commit, input logic flush);
        a_valid = v; a_fu = fu; a_lsu = lsu; a_fpu = fpu;
        a_done = done; a_commit = commit; a_flush = flush;
    endtask

    task automatic set_b(input logic v, input fu_class_t fu, input logic done);
        b_valid = v; b_fu = fu; b_done = done;
        b_lsu = 1'b0; b_fpu = 1'b0; b_commit = 1'b0; b_flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Reference model state for the random phase (MultLatency = 1)
    logic        m_rsv, m_busy, m_pend, blk, cr, e_rdy, acc;
    logic [6:0]  e_str;
    wb_sel_t     e_wb;
    logic [15:0] m_cnt;
    int          exp_stalls;

    initial begin
        rst_n = 1'b0;
        set_a(1'b0, FU_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_b(1'b0, FU_NONE, 1'b0);

        //                valid fu          lsu   fpu   done  flush rdy   strobes     wb
        tbl[0]  = '{1'b1, ALU,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1000000, WB_SINGLE};
        tbl[1]  = '{1'b1, CTRL_FLOW,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0100000, WB_SINGLE};
        tbl[2]  = '{1'b1, LOAD_STORE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000010, WB_NONE};
        tbl[3]  = '{1'b1, LOAD_STORE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, WB_NONE};
        tbl[4]  = '{1'b1, FPU,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0000001, WB_NONE};
        tbl[5]  = '{1'b1, FPU,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, WB_NONE};
        tbl[6]  = '{1'b1, FU_NONE,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, WB_NONE};
        tbl[7]  = '{1'b1, ALU,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000, WB_NONE};
        tbl[8]  = '{1'b0, ALU,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000, WB_NONE};
        tbl[9]  = '{1'b0, MULT,       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000, WB_NONE};
        tbl[10] = '{1'b0, DIV,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000, WB_NONE};
        tbl[11] = '{1'b1, ALU,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0000000, WB_NONE};
        tbl[12] = '{1'b0, CSR,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0000000, WB_NONE};

        #12;
        chk("reset.cnt", 32'(a_cnt), 32'h0);
        chk("reset.wb", 32'(a_wb), 32'(WB_NONE));
        chk("reset.rsv_b", 32'(dut_b.rsv_q), 32'h0);
        chk("reset.busy", 32'(dut_a.div_busy_q), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed vectors from idle state
        exp_stalls = 0;
        for (int i = 0; i < 13; i++) begin
            set_a(tbl[i].valid, tbl[i].fu, tbl[i].lsu, tbl[i].fpu, tbl[i].done, 1'b0, tbl[i].flush);
            if (tbl[i].valid && !tbl[i].exp_ready) exp_stalls++;
            smp();
            chk($sformatf("vec%0d.ready", i), 32'(a_ready), 32'(tbl[i].exp_ready));
            chk($sformatf("vec%0d.strobes", i), 32'(a_str), 32'(tbl[i].exp_str));
            chk($sformatf("vec%0d.wb", i), 32'(a_wb), 32'(tbl[i].exp_wb));
            step();
        end
        set_a(1'b0, FU_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        smp();
        chk("vec.stall_cnt", 32'(a_cnt), 32'(exp_stalls));
        step();

        // MULT then ALU with MultLatency = 1
        set_a(1'b1, MULT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        smp(); chk("ml1.mult_issue", 32'(a_str), 32'h08);
        step();
        set_a(1'b1, ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        smp(); chk("ml1.alu_stall", 32'(a_ready), 32'h0);
        chk("ml1.wb_mult", 32'(a_wb), 32'(WB_MULT));
        step();
        smp(); chk("ml1.alu_issue", 32'(a_str), 32'h40);
        chk("ml1.wb_single", 32'(a_wb), 32'(WB_SINGLE));
        step();

        // DIV blocks everything until div_done_i
        rst_n = 1'b0; set_a(1'b0, FU_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); rst_n = 1'b1;
        set_a(1'b1, DIV, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        smp(); chk("div.issue", 32'(a_str), 32'h04);
        step();
        for (int k = 0; k < 10; k++) begin
            set_a(1'b1, (k % 3 == 0) ? ALU : (k % 3 == 1) ? LOAD_STORE : FPU,
                  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            smp();
            chk($sformatf("div.block%0d", k), 32'({a_ready, a_str}), 32'h0);
            step();
        end
        set_a(1'b0, FU_NONE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        smp(); chk("div.wb_div", 32'(a_wb), 32'(WB_DIV));
        chk("div.stall_cnt", 32'(a_cnt), 32'd10);
        step();
        set_a(1'b1, ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        smp(); chk("div.alu_after", 32'(a_str), 32'h40);
        chk("div.wb_single", 32'(a_wb), 32'(WB_SINGLE));
        step();

        // CSR blocks until commit; commit with flush clears pending
        set_a(1'b1, CSR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        smp(); chk("csr.issue", 32'(a_str), 32'h10);
        step();
        set_a(1'b1, ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        smp(); chk("csr.block", 32'(a_ready), 32'h0);
        step();
        set_a(1'b1, ALU, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        smp(); chk("csr.flush_block", 32'(a_ready), 32'h0);
        step();
        set_a(1'b1, ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        smp(); chk("csr.pending_clr", 32'(dut_a.csr_pending_q), 32'h0);
        chk("csr.alu_after", 32'(a_str), 32'h40);
        step();
        set_a(1'b0, FU_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // MultLatency = 3: DIV waits out all three reserved slots
        set_b(1'b1, MULT, 1'b0);
        smp(); chk("ml3.mult_issue", 32'(b_mul), 32'h1);
        step();
        set_b(1'b1, DIV, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            smp(); chk($sformatf("ml3.div_stall%0d", k), 32'(b_ready), 32'h0);
            if (k == 3) chk("ml3.wb_mult", 32'(b_wb), 32'(WB_MULT));
            step();
        end
        smp(); chk("ml3.div_issue", 32'(b_div), 32'h1);
        chk("ml3.stall_cnt", 32'(b_cnt), 32'd3);
        step();
        set_b(1'b0, FU_NONE, 1'b1);
        smp(); chk("ml3.wb_div", 32'(b_wb), 32'(WB_DIV));
        step();
        set_b(1'b0, FU_NONE, 1'b0);

        // Long stall saturates the counter; flush leaves it alone
        set_a(1'b1, LOAD_STORE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (70000) @(posedge clk);
        #1 a_flush = 1'b1;
        smp(); chk("sat.cnt", 32'(a_cnt), 32'hFFFF);
        step();
        a_flush = 1'b0;
        smp(); chk("sat.after_flush", 32'(a_cnt), 32'hFFFF);
        step();

        // Asynchronous reset mid-divide / mid-multiply
        set_a(1'b1, DIV, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_b(1'b1, MULT, 1'b0);
        step();
        set_a(1'b0, FU_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_b(1'b0, FU_NONE, 1'b0);
        chk("arst.pre_busy", 32'(dut_a.div_busy_q), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.busy", 32'(dut_a.div_busy_q), 32'h0);
        chk("arst.cnt", 32'(a_cnt), 32'h0);
        chk("arst.rsv_b", 32'(dut_b.rsv_q), 32'h0);
        step(); rst_n = 1'b1;
        set_b(1'b0, DIV, 1'b0);
        a_fu = DIV;
        smp(); chk("arst.div_ready_a", 32'(a_ready), 32'h1);
        chk("arst.div_ready_b", 32'(b_ready), 32'h1);
        step();

        // Random phase against reference model, from a fresh reset
        rst_n = 1'b0; set_a(1'b0, FU_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); rst_n = 1'b1;
        m_rsv = 1'b0; m_busy = 1'b0; m_pend = 1'b0; m_cnt = 16'd0;
        for (int c = 0; c < 400; c++) begin
            set_a($urandom_range(0, 3) != 0, fu_class_t'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0);
            blk = a_flush || m_busy || m_pend || (a_fu == FU_NONE);
            case (a_fu)
                ALU, CTRL_FLOW, CSR: cr = !m_rsv && !a_done;
                MULT:                cr = 1'b1;
                DIV:                 cr = !m_rsv;
                LOAD_STORE:          cr = a_lsu;
                FPU:                 cr = a_fpu;
                default:             cr = 1'b0;
            endcase
            e_rdy = !blk && cr;
            acc   = a_valid && e_rdy;
            e_str = acc ? 7'(7'h40 >> (int'(a_fu) - 1)) : 7'h0;
            if (acc && (a_fu == ALU || a_fu == CTRL_FLOW || a_fu == CSR)) e_wb = WB_SINGLE;
            else if (m_rsv)                                             e_wb = WB_MULT;
            else if (a_done && m_busy)                                  e_wb = WB_DIV;
            else                                                        e_wb = WB_NONE;
            smp();
            chk($sformatf("rnd%0d.ready", c), 32'(a_ready), 32'(e_rdy));
            chk($sformatf("rnd%0d.strobes", c), 32'(a_str), 32'(e_str));
            chk($sformatf("rnd%0d.onehot", c), 32'($countones(a_str) <= 1), 32'h1);
            chk($sformatf("rnd%0d.wb", c), 32'(a_wb), 32'(e_wb));
            chk($sformatf("rnd%0d.cnt", c), 32'(a_cnt), 32'(m_cnt));
            if (a_valid && !e_rdy && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (a_flush) begin
                m_rsv = 1'b0; m_busy = 1'b0; m_pend = 1'b0;
            end else begin
                m_rsv = acc && (a_fu == MULT);
                if (acc && a_fu == DIV) m_busy = 1'b1;
                else if (a_done)        m_busy = 1'b0;
                if (acc && a_fu == CSR) m_pend = 1'b1;
                else if (a_commit)      m_pend = 1'b0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
